// File: rtl/noc_pkg.sv
// Shared NoC definitions: port ids, header field offsets, eject FSM states.
package noc_pkg;

  localparam logic [2:0] NULL   = 3'd0;
  localparam logic [2:0] BOTTOM = 3'd1;
  localparam logic [2:0] RIGHT  = 3'd2;
  localparam logic [2:0] TOP    = 3'd3;
  localparam logic [2:0] LEFT   = 3'd4;
  localparam logic [2:0] LOCAL  = 3'd5;

  // X fields sit at fixed offsets; Y fields follow their X field directly,
  // so their offsets depend on the coordinate width.
  localparam int unsigned DST_X_LSB = 0;
  localparam int unsigned SRC_X_LSB = 8;
  localparam int unsigned LEN_LSB   = 16;

  function automatic int unsigned dst_y_lsb(input int unsigned xy_sz);
    return DST_X_LSB + xy_sz;
  endfunction

  function automatic int unsigned src_y_lsb(input int unsigned xy_sz);
    return SRC_X_LSB + xy_sz;
  endfunction

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    PAY  = 2'd1,
    DROP = 2'd2
  } eject_state_e;

endpackage

// File: rtl/noc_skid_2.sv
// Two-entry skid buffer; upstream ready is registered so the downstream
// ready never reaches the producer combinationally.
module noc_skid_2 #(
  parameter int unsigned WIDTH = 37
) (
  input  logic             clk_line,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
);

  logic [WIDTH-1:0] r_mem [2];
  logic [1:0]       r_cnt;
  logic             r_rdy;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_cnt_nxt;
  logic             w_wr_idx;

  assign w_push  = i_valid & r_rdy;
  assign w_pop   = (r_cnt != 2'd0) & i_ready;
  assign o_ready = r_rdy;
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_mem[0];

  // Next occupancy and the slot an incoming beat lands in after any pop.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_wr_idx  = 1'b0;
    if (w_push && !w_pop) w_cnt_nxt = r_cnt + 2'd1;
    if (!w_push && w_pop) w_cnt_nxt = r_cnt - 2'd1;
    if (w_pop) w_wr_idx = (r_cnt == 2'd2);
    else       w_wr_idx = (r_cnt == 2'd1);
  end

  // Storage, occupancy and registered ready.
  always_ff @(posedge clk_line) begin
    if (!rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_cnt    <= '0;
      r_rdy    <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_rdy <= (w_cnt_nxt != 2'd2);
      if (w_pop)  r_mem[0]        <= r_mem[1];
      if (w_push) r_mem[w_wr_idx] <= i_data;
    end
  end

endmodule

// File: rtl/noc_local_eject.sv
// LOCAL-port eject stage: decodes/strips headers, drops misrouted packets,
// checks payload length and delivers payload through a 2-entry skid.
module noc_local_eject
  import noc_pkg::*;
#(
  parameter int unsigned XY_SZ = 3,
  parameter int unsigned LEN_W = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_line,
  input  logic             rst,
  input  logic [XY_SZ-1:0] myX,
  input  logic [XY_SZ-1:0] myY,
  input  logic             stream_in_TVALID,
  input  logic [31:0]      stream_in_TDATA,
  input  logic [3:0]       stream_in_TKEEP,
  input  logic             stream_in_TLAST,
  output logic             stream_in_TREADY,
  output logic             stream_out_TVALID,
  output logic [31:0]      stream_out_TDATA,
  output logic [3:0]       stream_out_TKEEP,
  output logic             stream_out_TLAST,
  input  logic             stream_out_TREADY,
  output logic             hdr_valid,
  output logic [XY_SZ-1:0] hdr_src_x,
  output logic [XY_SZ-1:0] hdr_src_y,
  output logic [LEN_W-1:0] hdr_len,
  output logic             err_dest,
  output logic             err_len,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int unsigned DST_Y_LSB = dst_y_lsb(XY_SZ);
  localparam int unsigned SRC_Y_LSB = src_y_lsb(XY_SZ);

  eject_state_e r_state, w_state_nxt;

  logic [XY_SZ-1:0] r_src_x, r_src_y;
  logic [LEN_W-1:0] r_len, r_wcnt, w_wcnt_inc;
  logic [CNT_W-1:0] r_pkt, r_drop;
  logic             r_hdr_valid, r_err_dest, r_err_len;

  logic             w_in_ready, w_accept, w_dest_ok;
  logic [XY_SZ-1:0] w_dst_x, w_dst_y;
  logic [LEN_W-1:0] w_len;
  logic             w_hdr_take, w_hv, w_ed, w_el, w_pkt_inc, w_drop_inc;
  logic             w_push, w_wcnt_clr, w_wcnt_en;

  assign w_accept   = stream_in_TVALID & w_in_ready;
  assign w_dst_x    = stream_in_TDATA[DST_X_LSB +: XY_SZ];
  assign w_dst_y    = stream_in_TDATA[DST_Y_LSB +: XY_SZ];
  assign w_len      = stream_in_TDATA[LEN_LSB +: LEN_W];
  assign w_dest_ok  = (w_dst_x == myX) && (w_dst_y == myY);
  assign w_wcnt_inc = (&r_wcnt) ? r_wcnt : r_wcnt + LEN_W'(1);

  // FSM state register.
  always_ff @(posedge clk_line) begin
    if (!rst) r_state <= HDR;
    else      r_state <= w_state_nxt;
  end

  // Next state and per-beat actions.
  always_comb begin
    w_state_nxt = r_state;
    w_hdr_take  = 1'b0;
    w_hv        = 1'b0;
    w_ed        = 1'b0;
    w_el        = 1'b0;
    w_pkt_inc   = 1'b0;
    w_drop_inc  = 1'b0;
    w_push      = 1'b0;
    w_wcnt_clr  = 1'b0;
    w_wcnt_en   = 1'b0;
    case (r_state)
      HDR: if (w_accept) begin
        w_hdr_take = 1'b1;
        if (!w_dest_ok) begin
          w_ed        = 1'b1;
          w_drop_inc  = 1'b1;
          w_state_nxt = stream_in_TLAST ? HDR : DROP;
        end else if (stream_in_TLAST) begin
          w_hv      = 1'b1;
          w_pkt_inc = 1'b1;
          w_el      = (w_len != '0);
        end else begin
          w_hv        = 1'b1;
          w_wcnt_clr  = 1'b1;
          w_state_nxt = PAY;
        end
      end
      PAY: if (w_accept) begin
        w_push    = 1'b1;
        w_wcnt_en = 1'b1;
        if (stream_in_TLAST) begin
          w_pkt_inc   = 1'b1;
          w_el        = (w_wcnt_inc != r_len);
          w_state_nxt = HDR;
        end
      end
      DROP: if (w_accept && stream_in_TLAST) w_state_nxt = HDR;
      default: w_state_nxt = HDR;
    endcase
  end

  // Header fields, status pulses, word counter and statistics.
  always_ff @(posedge clk_line) begin
    if (!rst) begin
      r_src_x     <= '0;
      r_src_y     <= '0;
      r_len       <= '0;
      r_wcnt      <= '0;
      r_pkt       <= '0;
      r_drop      <= '0;
      r_hdr_valid <= 1'b0;
      r_err_dest  <= 1'b0;
      r_err_len   <= 1'b0;
    end else begin
      r_hdr_valid <= w_hv;
      r_err_dest  <= w_ed;
      r_err_len   <= w_el;
      if (w_hdr_take) begin
        r_src_x <= stream_in_TDATA[SRC_X_LSB +: XY_SZ];
        r_src_y <= stream_in_TDATA[SRC_Y_LSB +: XY_SZ];
        r_len   <= w_len;
      end
      if (w_wcnt_clr)     r_wcnt <= '0;
      else if (w_wcnt_en) r_wcnt <= w_wcnt_inc;
      if (w_pkt_inc)  r_pkt  <= r_pkt + CNT_W'(1);
      if (w_drop_inc) r_drop <= r_drop + CNT_W'(1);
    end
  end

  noc_skid_2 #(.WIDTH(37)) u_skid (
    .clk_line (clk_line),
    .rst      (rst),
    .i_valid  (w_push),
    .i_data   ({stream_in_TLAST, stream_in_TKEEP, stream_in_TDATA}),
    .o_ready  (w_in_ready),
    .o_valid  (stream_out_TVALID),
    .o_data   ({stream_out_TLAST, stream_out_TKEEP, stream_out_TDATA}),
    .i_ready  (stream_out_TREADY)
  );

  assign stream_in_TREADY = w_in_ready;
  assign hdr_valid        = r_hdr_valid;
  assign hdr_src_x        = r_src_x;
  assign hdr_src_y        = r_src_y;
  assign hdr_len          = r_len;
  assign err_dest         = r_err_dest;
  assign err_len          = r_err_len;
  assign pkt_count        = r_pkt;
  assign drop_count       = r_drop;

endmodule

// File: tb/tb_noc_local_eject.sv
// Directed table-driven bench for noc_local_eject plus stall/reset sequences.
module tb_noc_local_eject;

  logic        clk_line = 1'b0;
  logic        rst;
  logic [2:0]  myX, myY;
  logic        in_vld, in_last, in_rdy;
  logic [31:0] in_data;
  logic [3:0]  in_keep;
  logic        out_vld, out_last, out_rdy;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        hv, ed, el;
  logic [2:0]  sx, sy;
  logic [15:0] hlen, pkt, drop;

  int total = 0;
  int bad   = 0;

  always #5 clk_line = ~clk_line;

  noc_local_eject #(.XY_SZ(3), .LEN_W(16), .CNT_W(16)) dut (
    .clk_line          (clk_line),
    .rst               (rst),
    .myX               (myX),
    .myY               (myY),
    .stream_in_TVALID  (in_vld),
    .stream_in_TDATA   (in_data),
    .stream_in_TKEEP   (in_keep),
    .stream_in_TLAST   (in_last),
    .stream_in_TREADY  (in_rdy),
    .stream_out_TVALID (out_vld),
    .stream_out_TDATA  (out_data),
    .stream_out_TKEEP  (out_keep),
    .stream_out_TLAST  (out_last),
    .stream_out_TREADY (out_rdy),
    .hdr_valid         (hv),
    .hdr_src_x         (sx),
    .hdr_src_y         (sy),
    .hdr_len           (hlen),
    .err_dest          (ed),
    .err_len           (el),
    .pkt_count         (pkt),
    .drop_count        (drop)
  );

  typedef struct {
    logic        vld;
    logic [31:0] data;
    logic        last;
    logic        ovld;
    logic [31:0] odata;
    logic        olast;
    logic        hv, ed, el;
    int          pkt, drop, len, sx, sy;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(logic vld, logic [31:0] data, logic last,
                              logic ovld, logic [31:0] odata, logic olast,
                              logic h, logic e_d, logic e_l,
                              int p, int d, int ln, int x, int y);
    vec_t v;
    v.vld = vld; v.data = data; v.last = last;
    v.ovld = ovld; v.odata = odata; v.olast = olast;
    v.hv = h; v.ed = e_d; v.el = e_l;
    v.pkt = p; v.drop = d; v.len = ln; v.sx = x; v.sy = y;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_line);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l);
    in_vld = v; in_data = d; in_last = l;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   nsent, got, c, low_cnt;
    logic saw_el, acc, pop;
    logic [31:0] pdata;
    logic        plast;

    rst = 1'b0; myX = 3'd2; myY = 3'd1;
    in_vld = 1'b0; in_data = '0; in_last = 1'b0; in_keep = 4'hF; out_rdy = 1'b1;

    // hdr=0x0003_000A: dest (2,1), len 3, src (0,0)
    tbl[0]  = mk(1, 32'h0003_000A, 0, 0, 0,    0, 1, 0, 0, 0, 0, 3, 0, 0);
    tbl[1]  = mk(1, 32'h0000_000A, 0, 1, 'hA, 0, 0, 0, 0, 0, 0, 3, 0, 0);
    tbl[2]  = mk(1, 32'h0000_000B, 0, 1, 'hB, 0, 0, 0, 0, 0, 0, 3, 0, 0);
    tbl[3]  = mk(1, 32'h0000_000C, 1, 1, 'hC, 1, 0, 0, 0, 1, 0, 3, 0, 0);
    tbl[4]  = mk(0, 32'h0,         0, 0, 0,    0, 0, 0, 0, 1, 0, 3, 0, 0);
    // dest X=3: dropped
    tbl[5]  = mk(1, 32'h0002_000B, 0, 0, 0,    0, 0, 1, 0, 1, 1, 2, 0, 0);
    tbl[6]  = mk(1, 32'h0000_0001, 0, 0, 0,    0, 0, 0, 0, 1, 1, 2, 0, 0);
    tbl[7]  = mk(1, 32'h0000_0002, 1, 0, 0,    0, 0, 0, 0, 1, 1, 2, 0, 0);
    tbl[8]  = mk(1, 32'h0001_000A, 0, 0, 0,    0, 1, 0, 0, 1, 1, 1, 0, 0);
    tbl[9]  = mk(1, 32'h0000_000D, 1, 1, 'hD, 1, 0, 0, 0, 2, 1, 1, 0, 0);
    // len 4 but only 2 payload beats
    tbl[10] = mk(1, 32'h0004_000A, 0, 0, 0,    0, 1, 0, 0, 2, 1, 4, 0, 0);
    tbl[11] = mk(1, 32'h0000_000E, 0, 1, 'hE, 0, 0, 0, 0, 2, 1, 4, 0, 0);
    tbl[12] = mk(1, 32'h0000_000F, 1, 1, 'hF, 1, 0, 0, 1, 3, 1, 4, 0, 0);
    tbl[13] = mk(0, 32'h0,         0, 0, 0,    0, 0, 0, 0, 3, 1, 4, 0, 0);
    // header-only: len 0 (src 5,6), then len 1 -> length error
    tbl[14] = mk(1, 32'h0000_350A, 1, 0, 0,    0, 1, 0, 0, 4, 1, 0, 5, 6);
    tbl[15] = mk(1, 32'h0001_000A, 1, 0, 0,    0, 1, 0, 1, 5, 1, 1, 0, 0);
    tbl[16] = mk(0, 32'h0,         0, 0, 0,    0, 0, 0, 0, 5, 1, 1, 0, 0);

    // Reset state
    step(); step(); step();
    chk("reset_tready", 32'(in_rdy), 0);
    chk("reset_ovld", 32'(out_vld), 0);
    chk("reset_pkt", 32'(pkt), 0);
    chk("reset_hv", 32'(hv), 0);
    rst = 1'b1;
    step();
    chk("post_reset_tready", 32'(in_rdy), 1);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].vld, tbl[i].data, tbl[i].last);
      step();
      chk($sformatf("row%0d_ovld", i), 32'(out_vld), 32'(tbl[i].ovld));
      if (tbl[i].ovld) begin
        chk($sformatf("row%0d_odata", i), out_data, tbl[i].odata);
        chk($sformatf("row%0d_olast", i), 32'(out_last), 32'(tbl[i].olast));
        chk($sformatf("row%0d_okeep", i), 32'(out_keep), 32'hF);
      end
      chk($sformatf("row%0d_hv", i), 32'(hv), 32'(tbl[i].hv));
      chk($sformatf("row%0d_ed", i), 32'(ed), 32'(tbl[i].ed));
      chk($sformatf("row%0d_el", i), 32'(el), 32'(tbl[i].el));
      chk($sformatf("row%0d_pkt", i), 32'(pkt), tbl[i].pkt);
      chk($sformatf("row%0d_drop", i), 32'(drop), tbl[i].drop);
      chk($sformatf("row%0d_len", i), 32'(hlen), tbl[i].len);
      chk($sformatf("row%0d_sx", i), 32'(sx), tbl[i].sx);
      chk($sformatf("row%0d_sy", i), 32'(sy), tbl[i].sy);
      chk($sformatf("row%0d_irdy", i), 32'(in_rdy), 1);
    end

    // 8-beat packet, tile stalled in cycles 3..10 counted from the header
    nsent = 0; got = 0; c = 0; low_cnt = 0; saw_el = 1'b0;
    while (got < 8 && c < 60) begin
      out_rdy = !(c >= 3 && c <= 10);
      if (nsent == 0)     drive(1, 32'h0008_000A, 0);
      else if (nsent < 9) drive(1, 32'h100 + 32'(nsent - 1), nsent == 8);
      else                drive(0, 32'h0, 0);
      if (!in_rdy) low_cnt++;
      acc   = in_vld & in_rdy;
      pop   = out_vld & out_rdy;
      pdata = out_data;
      plast = out_last;
      step();
      if (acc) nsent++;
      if (el) saw_el = 1'b1;
      if (pop) begin
        chk($sformatf("stall_beat%0d_data", got), pdata, 32'h100 + 32'(got));
        chk($sformatf("stall_beat%0d_last", got), 32'(plast), 32'(got == 7));
        got++;
      end
      c++;
    end
    drive(0, 32'h0, 0);
    out_rdy = 1'b1;
    chk("stall_beats_delivered", 32'(got), 8);
    chk("stall_beats_accepted", 32'(nsent), 9);
    chk("stall_tready_low_cycles", 32'(low_cnt), 8);
    chk("stall_no_err_len", 32'(saw_el), 0);
    chk("stall_pkt", 32'(pkt), 6);
    step();
    chk("stall_drained", 32'(out_vld), 0);

    // Reset in the middle of a payload with beats held in the skid
    out_rdy = 1'b0;
    drive(1, 32'h0005_350A, 0); step();
    drive(1, 32'h0000_0200, 0); step();
    drive(1, 32'h0000_0201, 0); step();
    chk("midrst_skid_has_data", 32'(out_vld), 1);
    drive(0, 32'h0, 0);
    rst = 1'b0;
    step();
    chk("midrst_ovld", 32'(out_vld), 0);
    chk("midrst_pkt", 32'(pkt), 0);
    chk("midrst_drop", 32'(drop), 0);
    chk("midrst_len", 32'(hlen), 0);
    chk("midrst_sx", 32'(sx), 0);
    chk("midrst_tready", 32'(in_rdy), 0);
    rst = 1'b1;
    out_rdy = 1'b1;
    step();
    chk("midrst_tready_after", 32'(in_rdy), 1);
    drive(1, 32'h0000_000A, 1);
    step();
    chk("midrst_hdr_hv", 32'(hv), 1);
    chk("midrst_hdr_pkt", 32'(pkt), 1);
    chk("midrst_hdr_el", 32'(el), 0);
    chk("midrst_hdr_ovld", 32'(out_vld), 0);
    drive(0, 32'h0, 0);
    step();
    chk("midrst_hv_pulse", 32'(hv), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
